// File: rtl/sos_req_arbiter.sv
// sos_req_arbiter: round-robin sharing of one sum-of-squares datapath with tagged, credit-limited results.
// Optional: define SOS_ARB_CHECK_EN for the sticky protocol-error checker on err.
module sos_req_arbiter #(
    parameter int DATAWIDTH = 4,
    parameter int NUM_REQ = 4,
    parameter int RES_DEPTH = 8,
    localparam int TW = $clog2(NUM_REQ),
    localparam int RW = 2*DATAWIDTH+2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*4*DATAWIDTH-1:0] req_data,
    input  logic                           flush,
    output logic                           dp_valid,
    output logic [DATAWIDTH-1:0]           dp_a,
    output logic [DATAWIDTH-1:0]           dp_b,
    output logic [DATAWIDTH-1:0]           dp_c,
    output logic [DATAWIDTH-1:0]           dp_d,
    input  logic                           dp_o_valid,
    input  logic [RW-1:0]                  dp_result,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [TW-1:0]                  res_tag,
    output logic [RW-1:0]                  res_data,
    output logic                           busy,
    output logic                           err
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {RUN, DRAIN} state_t;
    state_t state;
    logic [TW-1:0] ptr, off, gnt, nxt;
    logic [TW:0] gsum;
    logic [2*NUM_REQ-1:0] rot;
    logic found, hs, t_pop, r_push, r_pop;
    logic [CW-1:0] in_flight, fifo_count;
    logic [CW:0] credit;
    logic [AW-1:0] t_wp, t_rp, r_wp, r_rp;
    logic [4*DATAWIDTH-1:0] slice;
    logic [TW-1:0] tag_mem [RES_DEPTH];
    logic [TW+RW-1:0] res_mem [RES_DEPTH];
    // Rotate so the search always starts at bit 0; lowest set bit is the winner.
    assign rot = {req_valid, req_valid} >> ptr;
    always_comb begin
        off = '0;
        found = 1'b0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                off = TW'(k);
                found = 1'b1;
            end
        end
    end
    assign gsum = {1'b0, ptr} + {1'b0, off};
    assign gnt = gsum >= (TW+1)'(NUM_REQ) ? TW'(gsum - (TW+1)'(NUM_REQ)) : TW'(gsum);
    assign nxt = gnt == TW'(NUM_REQ-1) ? '0 : gnt + TW'(1);
    assign credit = {1'b0, in_flight} + {1'b0, fifo_count};
    assign hs = rst && state == RUN && found && credit < (CW+1)'(RES_DEPTH);
    assign req_ready = hs ? NUM_REQ'(1) << gnt : '0;
    always_comb begin
        slice = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt == TW'(k)) slice = req_data[k*4*DATAWIDTH +: 4*DATAWIDTH];
    end
    assign t_pop = dp_o_valid && in_flight != '0;
    assign r_push = t_pop && fifo_count != CW'(RES_DEPTH);
    assign res_valid = fifo_count != '0;
    assign r_pop = res_valid && res_ready;
    assign {res_tag, res_data} = res_valid ? res_mem[r_rp] : '0;
    assign busy = in_flight != '0 || res_valid;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            ptr <= '0;
            dp_valid <= 1'b0;
            {dp_d, dp_c, dp_b, dp_a} <= '0;
            in_flight <= '0;
            fifo_count <= '0;
            t_wp <= '0;
            t_rp <= '0;
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            state <= state == RUN ? (flush ? DRAIN : RUN) : (!flush && in_flight == '0 ? RUN : DRAIN);
            dp_valid <= hs;
            if (hs) begin
                ptr <= nxt;
                {dp_d, dp_c, dp_b, dp_a} <= slice;
                t_wp <= t_wp + AW'(1);
            end
            if (t_pop) t_rp <= t_rp + AW'(1);
            if (r_push) r_wp <= r_wp + AW'(1);
            if (r_pop) r_rp <= r_rp + AW'(1);
            in_flight <= in_flight + CW'(hs) - CW'(t_pop);
            fifo_count <= fifo_count + CW'(r_push) - CW'(r_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (hs) tag_mem[t_wp] <= gnt;
        if (r_push) res_mem[r_wp] <= {tag_mem[t_rp], dp_result};
    end
`ifdef SOS_ARB_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if ((dp_o_valid && in_flight == '0) || (t_pop && fifo_count == CW'(RES_DEPTH))) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sos_req_arbiter.sv
// tb_sos_req_arbiter: randomized bench with a timestamped job-queue reference model and a 3-stage datapath.
module tb_sos_req_arbiter;
    localparam int DW = 4, NR = 4, RD = 8, L = 3, RW = 10, TW = 2;
    logic clk = 1'b0, rst = 1'b0;
    logic [NR-1:0] req_valid, req_ready;
    logic [63:0] req_data;
    logic flush, dp_valid, dp_o_valid, res_valid, res_ready, busy, err, inject;
    logic [DW-1:0] dp_a, dp_b, dp_c, dp_d;
    logic [RW-1:0] dp_result, res_data, sq;
    logic [TW-1:0] res_tag;
    logic [L-1:0] pv;
    logic [L-1:0][RW-1:0] pr;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    typedef struct { int tag; int val; int rdy; } job_t;
    job_t q[$];
    int ptr_m = 0;
    bit drain_m = 0, last_hs = 0, err_m = 0;
    logic [15:0] last_op = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sos_req_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .flush(flush), .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_o_valid(dp_o_valid), .dp_result(dp_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_tag(res_tag), .res_data(res_data), .busy(busy), .err(err)
    );

    // Latency-3 sum-of-squares datapath, cleared by the same reset.
    assign sq = RW'(dp_a)*RW'(dp_a) + RW'(dp_b)*RW'(dp_b) + RW'(dp_c)*RW'(dp_c) + RW'(dp_d)*RW'(dp_d);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            pr <= '0;
        end else begin
            pv <= {pv[L-2:0], dp_valid};
            pr <= {pr[L-2:0], sq};
        end
    end
    assign dp_o_valid = pv[L-1] | inject;
    assign dp_result = pr[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    task automatic cycle(input logic [NR-1:0] v, input logic [63:0] d, input bit rr, input bit fl, input bit inj);
        int g, inf;
        int a, b, c, e;
        logic [NR-1:0] exp_rdy;
        logic [15:0] op;
        bit rv;
        @(negedge clk);
        req_valid = v;
        req_data = d;
        res_ready = rr;
        flush = fl;
        inject = inj;
        #1;
        g = -1;
        if (!drain_m && q.size() < RD)
            for (int k = 0; k < NR; k++)
                if (g < 0 && v[TW'((ptr_m + k) % NR)]) g = (ptr_m + k) % NR;
        exp_rdy = g < 0 ? '0 : NR'(1) << g;
        inf = 0;
        foreach (q[j]) if (q[j].rdy > cyc) inf++;
        rv = q.size() > 0 && cyc >= q[0].rdy;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("dp_valid", 32'(dp_valid), 32'(last_hs));
        if (last_hs) check("dp_ops", 32'({dp_d, dp_c, dp_b, dp_a}), 32'(last_op));
        check("res_valid", 32'(res_valid), 32'(rv));
        if (rv) begin
            check("res_tag", 32'(res_tag), q[0].tag);
            check("res_data", 32'(res_data), q[0].val);
        end
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("err", 32'(err), 32'(err_m));
        if (rv && rr) void'(q.pop_front());
        last_hs = g >= 0;
        if (g >= 0) begin
            op = 16'(d >> (g*16));
            last_op = op;
            a = int'(op[3:0]);
            b = int'(op[7:4]);
            c = int'(op[11:8]);
            e = int'(op[15:12]);
            q.push_back('{g, a*a + b*b + c*c + e*e, cyc + 5});
            ptr_m = (g + 1) % NR;
        end
        if (!drain_m) drain_m = fl;
        else if (!fl && inf == 0) drain_m = 0;
`ifdef SOS_ARB_CHECK_EN
        if (inj && inf == 0) err_m = 1;
`endif
    endtask

    task automatic reset_mid();
        @(negedge clk);
        req_valid = '1;
        flush = 1'b0;
        inject = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dp_valid", 32'(dp_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        q.delete();
        ptr_m = 0;
        drain_m = 0;
        last_hs = 0;
        err_m = 0;
        req_valid = '0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        req_valid = '1;
        req_data = rnd();
        flush = 1'b0;
        res_ready = 1'b0;
        inject = 1'b0;
        #12;
        check("init_req_ready", 32'(req_ready), 0);
        check("init_dp_valid", 32'(dp_valid), 0);
        check("init_dp_ops", 32'({dp_d, dp_c, dp_b, dp_a}), 0);
        check("init_res_valid", 32'(res_valid), 0);
        check("init_res_tag", 32'(res_tag), 0);
        check("init_res_data", 32'(res_data), 0);
        check("init_busy", 32'(busy), 0);
        check("init_err", 32'(err), 0);
        @(negedge clk);
        req_valid = '0;
        #2 rst = 1'b1;
        cycle(4'b0100, 64'h0000_2143_0000_0000, 1, 0, 0);
        repeat (8) cycle('0, rnd(), 1, 0, 0);
        cycle(4'b0001, 64'h0000_0000_0000_FFFF, 1, 0, 0);
        repeat (8) cycle('0, rnd(), 1, 0, 0);
        repeat (40) cycle('1, rnd(), 1, 0, 0);
        repeat (300) cycle(NR'($urandom), rnd(), $urandom_range(0, 3) != 0, 0, 0);
        repeat (10) cycle('0, rnd(), 1, 0, 0);
        repeat (20) cycle('1, rnd(), 0, 0, 0);
        cycle('1, rnd(), 1, 0, 0);
        repeat (5) cycle('1, rnd(), 0, 0, 0);
        repeat (20) cycle('0, rnd(), 1, 0, 0);
        repeat (3) cycle('1, rnd(), 1, 0, 0);
        repeat (15) cycle('1, rnd(), $urandom_range(0, 1) != 0, 1, 0);
        repeat (10) cycle('1, rnd(), 1, 0, 0);
        repeat (300) cycle(NR'($urandom), rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, 0);
        repeat (15) cycle('1, rnd(), 0, 0, 0);
        reset_mid();
        cycle('1, rnd(), 1, 0, 0);
        repeat (10) cycle('0, rnd(), 1, 0, 0);
        cycle('0, rnd(), 1, 0, 1);
        repeat (3) cycle('0, rnd(), 1, 0, 0);
        repeat (50) cycle(NR'($urandom), rnd(), 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sos_req_arbiter.md
# sos_req_arbiter

Round-robin arbiter and sequencer that shares one sum-of-squares datapath (four squarers feeding a 4-input adder tree, valid-in/valid-out, no backpressure) between NUM_REQ requesters. It accepts operand vectors over per-requester valid/ready handshakes, issues one vector per cycle to the datapath, and tracks the requester tag of every in-flight job. It returns each result, with its tag, on a single valid/ready result port, using credit-based flow control so that no datapath output is ever dropped.

## Interface
- DATAWIDTH, 4, operand width; result width is 2*DATAWIDTH+2.
- NUM_REQ, 4, number of requesters (2..8); TW = $clog2(NUM_REQ).
- RES_DEPTH, 8, result FIFO depth, which is also the credit limit (power of two, ≥2).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero).
- req_data  in  NUM_REQ*4*DATAWIDTH  requester i occupies slice i, packed {D,C,B,A}.
- flush  in  1  stop granting and drain in-flight jobs.
- dp_valid  out  1  issue strobe to the datapath.
- dp_a, dp_b, dp_c, dp_d  out  DATAWIDTH each  issued operands.
- dp_o_valid  in  1  datapath result strobe.
- dp_result  in  2*DATAWIDTH+2  datapath sum.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_tag  out  TW  index of the originating requester.
- res_data  out  2*DATAWIDTH+2  sum of squares.
- busy  out  1  jobs in flight or FIFO not empty.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- Credits: credit_used = in_flight + fifo_count. A grant is allowed only when the state is RUN and credit_used < RES_DEPTH.
- Arbitration: round-robin.
  - Priority pointer resets to 0.
  - The first requester with req_valid, searching from the pointer upward with wrap, gets req_ready, which is combinational from req_valid, state and credits.
  - After a handshake (req_valid[i] & req_ready[i]), the pointer becomes (i+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is granted.
- Issue register: on a handshake, the next cycle drives dp_valid=1, dp_a..dp_d from slice i, and pushes tag i into the tag FIFO (depth RES_DEPTH). dp_valid=0 otherwise; dp_a..dp_d hold their last value.
- Result capture: on dp_o_valid, pop the tag FIFO and write {tag, dp_result} into the result FIFO. The datapath is in-order, so tags match by order.
- in_flight:
  - +1 on issue, -1 on dp_o_valid.
  - Simultaneous +1/-1 leaves it unchanged.
  - Simultaneous FIFO push and pop keep fifo_count unchanged.
- Result port: res_valid = result FIFO not empty; res_tag/res_data show the FIFO head; pop on res_valid & res_ready.
- FSM:
  - RUN → DRAIN when flush=1. No grants in DRAIN.
  - DRAIN → RUN when flush=0 and in_flight=0.
  - The result FIFO keeps draining in both states.
- busy = (in_flight≠0) | res_valid.
- Reset mid-operation clears the pointer, in_flight, both FIFOs and err, and sets the state to RUN. Results in flight in the datapath at reset are discarded, so the datapath must also be reset.

## Timing
- Reset values: req_ready=0, dp_valid=0, dp_a..dp_d=0, res_valid=0, res_tag=0, res_data=0, busy=0, err=0.
- Handshake at edge t: dp_valid is high in cycle t+1.
- With a datapath of latency L, dp_o_valid arrives at t+1+L, and res_valid rises at t+2+L if the FIFO was empty.
- Peak throughput is one job per cycle while credits remain.
- With res_ready held low, exactly RES_DEPTH jobs are accepted, then all req_ready=0 until a pop frees a credit. The first new grant is combinational in the cycle after the pop edge.

## Configuration
- SOS_ARB_CHECK_EN defined: err is set sticky (until reset) when either of these occurs:
  - dp_o_valid=1 while the tag FIFO is empty;
  - a result FIFO push while fifo_count = RES_DEPTH.

  In both cases the offending result is dropped.
- Not defined: the checker logic is removed and err is tied to 0.

## Test plan
- Single job, DATAWIDTH=4, L=3: requester 2 sends A=3,B=4,C=1,D=2 → one cycle later dp_valid=1; res_valid at accept+5 with res_tag=2, res_data=30.
- Max values: requester 0 sends A=B=C=D=15 → res_data=900, no truncation in the 10-bit result.
- Round-robin: all four requesters valid continuously with res_ready=1 → grants 0,1,2,3,0,… one per cycle; result tags appear in the same order.
- Backpressure: res_ready=0, all requesters valid → exactly 8 handshakes, then req_ready=0. Raising res_ready for 1 cycle pops one result (tag 0) and allows exactly one new grant.
- Flush: flush=1 with 3 jobs in flight → no new grants; busy stays 1 until the FIFO empties. Dropping flush after in_flight=0 resumes grants from the saved pointer.
- Reset mid-run: drive rst=0 asynchronously with 5 results buffered → res_valid, busy, dp_valid and err fall to 0 immediately. After release, the first grant goes to requester 0. With SOS_ARB_CHECK_EN, injecting dp_o_valid with no job issued sets err=1.
